data_checker: RTL and testbench

AXI4 write-only slave that terminates the bursts emitted by the team's AXI4-master data generator and verifies their content. It accepts one burst at a time on 512-bit AW/W/B channels, compares every beat against the generator's replicated 16-bit counting pattern, and returns a write response. Running burst, beat and error counters are exported as status ports for an adjacent AXI4-Lite register block or an ILA.

---
 rtl/data_checker.sv | 126 ++++++++++++
 tb/tb_data_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_checker.sv
// data_checker: AXI4 write slave verifying data-generator bursts; define DATA_CHECKER_FIRST_ERR_EN for first-error capture
module data_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [3:0]              S_AXI_AWID,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic [3:0]              S_AXI_BID,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic                    clear,
  output logic [31:0]             burst_count,
  output logic [31:0]             beat_count,
  output logic [31:0]             data_err_count,
  output logic [31:0]             proto_err_count,
  output logic [15:0]             expected_word,
  output logic [31:0]             first_err_beat,
  output logic [15:0]             first_err_data,
  output logic                    first_err_valid
);
  localparam int NW = DATA_WIDTH / 16;
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [7:0] awlen_q;
  logic [3:0] bid_q;
  logic [8:0] beat_idx;
  logic burst_err, proto_seen;
  logic aw_hs, w_hs, b_hs, full, at_last, proto_bad, data_bad;
  logic [DATA_WIDTH-1:0] byte_mask, ref_data;
  logic addr_unused;
  assign addr_unused = ^S_AXI_AWADDR;
  assign S_AXI_AWREADY = state == IDLE;
  assign S_AXI_WREADY = state == DATA;
  assign S_AXI_BVALID = state == RESP;
  assign S_AXI_BRESP = burst_err ? 2'b10 : 2'b00;
  assign S_AXI_BID = bid_q;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  assign b_hs = S_AXI_BVALID & S_AXI_BREADY;
  assign full = &S_AXI_WSTRB;
  assign at_last = beat_idx == {1'b0, awlen_q};
  assign proto_bad = S_AXI_WLAST != at_last;
  // beat compare: counting pattern on full beats, strobed bytes of BEEF on short beats
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < NB; i++) byte_mask[i*8 +: 8] = {8{S_AXI_WSTRB[i]}};
    ref_data = full ? {NW{expected_word}} : {NW{16'hBEEF}};
    data_bad = |((S_AXI_WDATA ^ ref_data) & byte_mask);
  end
  // one burst at a time: address, data beats up to WLAST, then response
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= aw_hs ? DATA : (w_hs && S_AXI_WLAST) ? RESP : b_hs ? IDLE : state;
  // per-burst context and pattern tracking
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      awlen_q <= '0;
      bid_q <= '0;
      beat_idx <= '0;
      burst_err <= 1'b0;
      proto_seen <= 1'b0;
      expected_word <= 16'h0001;
    end else if (aw_hs) begin
      awlen_q <= S_AXI_AWLEN;
      bid_q <= S_AXI_AWID;
      beat_idx <= '0;
      burst_err <= 1'b0;
      proto_seen <= 1'b0;
    end else if (w_hs) begin
      beat_idx <= &beat_idx ? beat_idx : beat_idx + 9'd1;
      burst_err <= burst_err | data_bad | proto_bad;
      proto_seen <= proto_seen | proto_bad;
      expected_word <= full ? expected_word + 16'd1 : 16'hBEEF;
    end
  // status counters; clear wins over a coincident update
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      burst_count <= '0;
      beat_count <= '0;
      data_err_count <= '0;
      proto_err_count <= '0;
    end else if (clear) begin
      burst_count <= '0;
      beat_count <= '0;
      data_err_count <= '0;
      proto_err_count <= '0;
    end else begin
      if (b_hs) burst_count <= burst_count + 32'd1;
      if (w_hs) beat_count <= beat_count + 32'd1;
      if (w_hs && data_bad) data_err_count <= data_err_count + 32'd1;
      if (w_hs && proto_bad && !proto_seen) proto_err_count <= proto_err_count + 32'd1;
    end
`ifdef DATA_CHECKER_FIRST_ERR_EN
  // latch the first data error until reset or clear re-arms it
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      first_err_valid <= 1'b0;
      first_err_beat <= '0;
      first_err_data <= '0;
    end else if (clear) begin
      first_err_valid <= 1'b0;
      first_err_beat <= '0;
      first_err_data <= '0;
    end else if (w_hs && data_bad && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_beat <= beat_count;
      first_err_data <= S_AXI_WDATA[15:0];
    end
`else
  assign first_err_valid = 1'b0;
  assign first_err_beat = '0;
  assign first_err_data = '0;
`endif
endmodule

// File: tb/tb_data_checker.sv
// tb_data_checker: table-driven and directed bursts against data_checker
module tb_data_checker;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int NW = DW / 16;
  localparam int NB = DW / 8;
  logic clk = 1'b0;
  logic resetn;
  logic [AW-1:0] S_AXI_AWADDR;
  logic [7:0] S_AXI_AWLEN;
  logic [3:0] S_AXI_AWID;
  logic S_AXI_AWVALID, S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA;
  logic [NB-1:0] S_AXI_WSTRB;
  logic S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0] S_AXI_BRESP;
  logic [3:0] S_AXI_BID;
  logic S_AXI_BVALID, S_AXI_BREADY;
  logic clear;
  logic [31:0] burst_count, beat_count, data_err_count, proto_err_count, first_err_beat;
  logic [15:0] expected_word, first_err_data;
  logic first_err_valid;
  int checks = 0;
  int errors = 0;

  data_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWID(S_AXI_AWID),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BID(S_AXI_BID),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .clear(clear), .burst_count(burst_count), .beat_count(beat_count),
    .data_err_count(data_err_count), .proto_err_count(proto_err_count),
    .expected_word(expected_word), .first_err_beat(first_err_beat),
    .first_err_data(first_err_data), .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] len;
    logic [3:0] id;
    int n;
    logic [15:0] w0;
    int bad;
    logic [15:0] badw;
    logic [1:0] resp;
    logic [31:0] beats;
    logic [31:0] bursts;
    logic [31:0] derr;
    logic [31:0] perr;
    logic [15:0] expw;
  } vec_t;
  vec_t v[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    S_AXI_AWLEN = len;
    S_AXI_AWID = id;
    S_AXI_AWADDR = 64'h1000;
    S_AXI_AWVALID = 1'b1;
    while (!S_AXI_AWREADY && n < 50) begin tick; n++; end
    chk("aw_ready", S_AXI_AWREADY, 1);
    tick;
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic beat_raw(input logic [DW-1:0] d, input logic [NB-1:0] s, input logic last);
    int n = 0;
    S_AXI_WDATA = d;
    S_AXI_WSTRB = s;
    S_AXI_WLAST = last;
    S_AXI_WVALID = 1'b1;
    while (!S_AXI_WREADY && n < 50) begin tick; n++; end
    if (!S_AXI_WREADY) chk("w_ready_timeout", S_AXI_WREADY, 1);
    tick;
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic beat(input logic [15:0] w, input logic last);
    beat_raw({NW{w}}, '1, last);
  endtask

  task automatic burst(input logic [7:0] len, input logic [3:0] id, input int n,
                       input logic [15:0] w0, input int bad, input logic [15:0] badw);
    do_aw(len, id);
    for (int k = 0; k < n; k++) beat(k == bad ? badw : w0 + 16'(k), k == n - 1);
  endtask

  task automatic resp(input logic [1:0] er, input logic [3:0] eid, input int hold);
    chk("b_valid_rise", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID}, {1'b1, er, eid});
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("b_hold", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID}, {1'b1, er, eid});
    end
    S_AXI_BREADY = 1'b1;
    tick;
    S_AXI_BREADY = 1'b0;
    chk("after_b", {S_AXI_AWREADY, S_AXI_BVALID}, 2'b10);
  endtask

  initial begin
    v[0] = '{8'd3, 4'h5, 4, 16'd1,  -1, 16'h0,    2'd0, 32'd4,  32'd1, 32'd0, 32'd0, 16'd5};
    v[1] = '{8'd0, 4'h3, 1, 16'd5,  -1, 16'h0,    2'd0, 32'd5,  32'd2, 32'd0, 32'd0, 16'd6};
    v[2] = '{8'd1, 4'hA, 2, 16'd6,   1, 16'h1234, 2'd2, 32'd7,  32'd3, 32'd1, 32'd0, 16'd8};
    v[3] = '{8'd1, 4'h1, 1, 16'd8,  -1, 16'h0,    2'd2, 32'd8,  32'd4, 32'd1, 32'd1, 16'd9};
    v[4] = '{8'd1, 4'h2, 3, 16'd9,  -1, 16'h0,    2'd2, 32'd11, 32'd5, 32'd1, 32'd2, 16'd12};
    v[5] = '{8'd2, 4'hF, 3, 16'd12, -1, 16'h0,    2'd0, 32'd14, 32'd6, 32'd1, 32'd2, 16'd15};
    resetn = 1'b0;
    clear = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWID = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    S_AXI_WDATA = {NW{16'h0001}};
    S_AXI_WSTRB = '1;
    S_AXI_WLAST = 1'b1;
    S_AXI_WVALID = 1'b1;
    tick;
    tick;
    chk("rst_hs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID}, {3'b100, 2'b0, 4'b0});
    chk("rst_expw", expected_word, 16'h0001);
    chk("rst_cnt", {burst_count, beat_count}, 64'd0);
    chk("rst_err", {data_err_count, proto_err_count}, 64'd0);
    chk("rst_fe", {first_err_valid, first_err_beat, first_err_data}, 0);
    S_AXI_WVALID = 1'b0;

    for (int i = 0; i < 6; i++) begin
      burst(v[i].len, v[i].id, v[i].n, v[i].w0, v[i].bad, v[i].badw);
      resp(v[i].resp, v[i].id, 0);
      chk($sformatf("v%0d_beats", i), beat_count, v[i].beats);
      chk($sformatf("v%0d_bursts", i), burst_count, v[i].bursts);
      chk($sformatf("v%0d_derr", i), data_err_count, v[i].derr);
      chk($sformatf("v%0d_perr", i), proto_err_count, v[i].perr);
      chk($sformatf("v%0d_expw", i), expected_word, v[i].expw);
    end
`ifdef DATA_CHECKER_FIRST_ERR_EN
    chk("table_fe", {first_err_valid, first_err_beat, first_err_data}, {1'b1, 32'd6, 16'h1234});
`else
    chk("table_fe", {first_err_valid, first_err_beat, first_err_data}, 0);
`endif

    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr_cnt", {burst_count, beat_count}, 64'd0);
    chk("clr_err", {data_err_count, proto_err_count}, 64'd0);
    chk("clr_expw", expected_word, 16'd15);
    chk("clr_fe", {first_err_valid, first_err_beat, first_err_data}, 0);

    burst(8'd3, 4'hC, 4, 16'd15, 2, 16'h0007);
    resp(2'd2, 4'hC, 0);
    chk("err_derr", data_err_count, 32'd1);
    chk("err_beats", beat_count, 32'd4);
    chk("err_expw", expected_word, 16'd19);
`ifdef DATA_CHECKER_FIRST_ERR_EN
    chk("err_fe", {first_err_valid, first_err_beat, first_err_data}, {1'b1, 32'd2, 16'h0007});
`else
    chk("err_fe", {first_err_valid, first_err_beat, first_err_data}, 0);
`endif

    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    tick;
    chk("rst2_expw", expected_word, 16'h0001);
    for (int b = 0; b < 3; b++) begin
      burst(8'd255, 4'(b + 1), 256, 16'(1 + 256 * b), -1, 16'h0);
      resp(2'd0, 4'(b + 1), 5);
    end
    chk("long_beats", beat_count, 32'd768);
    chk("long_bursts", burst_count, 32'd3);
    chk("long_expw", expected_word, 16'd769);
    chk("long_err", {data_err_count, proto_err_count}, 64'd0);

    do_aw(8'd0, 4'h7);
    beat_raw({{(NW - 1){16'h5A5A}}, 16'hBEEF}, 64'h3, 1'b1);
    resp(2'd0, 4'h7, 0);
    chk("short_expw", expected_word, 16'hBEEF);
    do_aw(8'd0, 4'h8);
    beat_raw({{(NW - 1){16'hBEEF}}, 16'hBE00}, 64'h1, 1'b1);
    resp(2'd2, 4'h8, 0);
    chk("short_bad_derr", data_err_count, 32'd1);
    burst(8'd0, 4'h9, 1, 16'hBEEF, -1, 16'h0);
    resp(2'd0, 4'h9, 0);
    chk("short_full_expw", expected_word, 16'hBEF0);
    chk("short_full_derr", data_err_count, 32'd1);

    do_aw(8'd1, 4'h4);
    clear = 1'b1;
    beat(16'hBEF0, 1'b0);
    clear = 1'b0;
    chk("clr_beat_cnt", {burst_count, beat_count, data_err_count}, 0);
    chk("clr_beat_expw", expected_word, 16'hBEF1);
    beat(16'hBEF1, 1'b1);
    resp(2'd0, 4'h4, 0);
    chk("clr_after", {burst_count, beat_count}, {32'd1, 32'd1});

    do_aw(8'd3, 4'h6);
    beat(16'hBEF2, 1'b0);
    chk("mid_beats", beat_count, 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, beat_count}, {3'b100, 32'd0});
    tick;
    resetn = 1'b1;
    tick;
    chk("mid_rst_hs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b100);
    chk("mid_rst_cnt", {burst_count, beat_count}, 64'd0);
    chk("mid_rst_expw", expected_word, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
